// File: rtl/tournament_tracker.sv
// tournament_tracker: in-order queue of in-flight predicted branches for the
// chooser side of a tournament predictor. Allocated at fetch, popped at
// resolve; produces selector training handshake, component-table training
// index/outcome, mispredict pulse, and wrong-path squash.
module tournament_tracker #(
    parameter int DEPTH = 8,
    parameter int IDX_W = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alloc_valid,
    input  logic [IDX_W-1:0]         alloc_idx,
    input  logic                     alloc_p1,
    input  logic                     alloc_p2,
    input  logic                     sel,
    output logic                     alloc_ready,
    output logic                     pred_taken,
    input  logic                     resolve_valid,
    input  logic                     resolve_taken,
    output logic                     resolve_ready,
    output logic                     p1_cor,
    output logic                     p2_cor,
    output logic                     update,
    output logic [IDX_W-1:0]         upd_idx,
    output logic                     upd_taken,
    output logic                     mispredict,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             p1;
        logic             p2;
        logic             chosen;
    } entry_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE
    } state_t;

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    state_t           state_q, state_d;

    logic             p1_cor_q, p1_cor_d;
    logic             p2_cor_q, p2_cor_d;
    logic [IDX_W-1:0] upd_idx_q, upd_idx_d;
    logic             upd_taken_q, upd_taken_d;
    logic             mispredict_q, mispredict_d;

    entry_t head_entry;
    entry_t new_entry;
    logic   res_acc;
    logic   mis;
    logic   squash;
    logic   alloc_acc;

    // Handshake decode: readiness comes only from registered state/count.
    always_comb begin
        pred_taken    = sel ? alloc_p2 : alloc_p1;
        alloc_ready   = (count_q != FULL);
        resolve_ready = (state_q == S_IDLE);
        update        = (state_q == S_PULSE);
        head_entry    = mem_q[head_q];
        new_entry     = '{idx: alloc_idx, p1: alloc_p1, p2: alloc_p2, chosen: pred_taken};
        res_acc       = resolve_valid && resolve_ready && (count_q != '0);
        mis           = (head_entry.chosen != resolve_taken);
        squash        = res_acc && mis;
        // A mispredict discards the wrong-path allocation on the same edge.
        alloc_acc     = alloc_valid && alloc_ready && !squash;
    end

    // Next-state for queue pointers, occupancy, training FSM and result regs.
    always_comb begin
        // NOTE: every always_comb target gets a default first so no latch is inferred.
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        state_d      = state_q;
        p1_cor_d     = p1_cor_q;
        p2_cor_d     = p2_cor_q;
        upd_idx_d    = upd_idx_q;
        upd_taken_d  = upd_taken_q;
        mispredict_d = 1'b0;

        if (alloc_acc) begin
            tail_d = tail_q + PTR_W'(1);
        end
        if (res_acc) begin
            head_d       = head_q + PTR_W'(1);
            p1_cor_d     = (head_entry.p1 == resolve_taken);
            p2_cor_d     = (head_entry.p2 == resolve_taken);
            upd_idx_d    = head_entry.idx;
            upd_taken_d  = resolve_taken;
            mispredict_d = mis;
        end

        if (squash) begin
            tail_d  = head_q + PTR_W'(1);
            count_d = '0;
        end else if (alloc_acc && !res_acc) begin
            count_d = count_q + CNT_W'(1);
        end else if (res_acc && !alloc_acc) begin
            count_d = count_q - CNT_W'(1);
        end

        unique case (state_q)
            S_IDLE:  if (res_acc) state_d = S_SETUP;
            S_SETUP: state_d = S_PULSE;
            S_PULSE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Control and result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            state_q      <= S_IDLE;
            p1_cor_q     <= 1'b0;
            p2_cor_q     <= 1'b0;
            upd_idx_q    <= '0;
            upd_taken_q  <= 1'b0;
            mispredict_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            state_q      <= state_d;
            p1_cor_q     <= p1_cor_d;
            p2_cor_q     <= p2_cor_d;
            upd_idx_q    <= upd_idx_d;
            upd_taken_q  <= upd_taken_d;
            mispredict_q <= mispredict_d;
        end
    end

    // Entry storage write at the tail.
    // NOTE: storage is not reset; count/pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (alloc_acc) begin
            mem_q[tail_q] <= new_entry;
        end
    end

    assign p1_cor     = p1_cor_q;
    assign p2_cor     = p2_cor_q;
    assign upd_idx    = upd_idx_q;
    assign upd_taken  = upd_taken_q;
    assign mispredict = mispredict_q;
    assign count      = count_q;

endmodule

// File: tb/tb_tournament_tracker.sv
// Directed testbench for tournament_tracker (DEPTH=8, IDX_W=5).
module tb_tournament_tracker;

    localparam int DEPTH = 8;
    localparam int IDX_W = 5;

    logic             clk;
    logic             rst;
    logic             alloc_valid;
    logic [IDX_W-1:0] alloc_idx;
    logic             alloc_p1;
    logic             alloc_p2;
    logic             sel;
    logic             alloc_ready;
    logic             pred_taken;
    logic             resolve_valid;
    logic             resolve_taken;
    logic             resolve_ready;
    logic             p1_cor;
    logic             p2_cor;
    logic             update;
    logic [IDX_W-1:0] upd_idx;
    logic             upd_taken;
    logic             mispredict;
    logic [3:0]       count;

    int checks = 0;
    int errors = 0;

    tournament_tracker #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .alloc_valid   (alloc_valid),
        .alloc_idx     (alloc_idx),
        .alloc_p1      (alloc_p1),
        .alloc_p2      (alloc_p2),
        .sel           (sel),
        .alloc_ready   (alloc_ready),
        .pred_taken    (pred_taken),
        .resolve_valid (resolve_valid),
        .resolve_taken (resolve_taken),
        .resolve_ready (resolve_ready),
        .p1_cor        (p1_cor),
        .p2_cor        (p2_cor),
        .update        (update),
        .upd_idx       (upd_idx),
        .upd_taken     (upd_taken),
        .mispredict    (mispredict),
        .count         (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock edge; inputs change and outputs are sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_alloc(input logic v, input logic [IDX_W-1:0] idx,
                             input logic p1, input logic p2, input logic s);
        alloc_valid = v;
        alloc_idx   = idx;
        alloc_p1    = p1;
        alloc_p2    = p2;
        sel         = s;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_count"}, 32'(count), 32'd0);
        check({tag, "_update"}, 32'(update), 32'd0);
        check({tag, "_mis"}, 32'(mispredict), 32'd0);
        check({tag, "_p1cor"}, 32'(p1_cor), 32'd0);
        check({tag, "_p2cor"}, 32'(p2_cor), 32'd0);
        check({tag, "_uidx"}, 32'(upd_idx), 32'd0);
        check({tag, "_utaken"}, 32'(upd_taken), 32'd0);
    endtask

    initial begin
        int pulses;
        logic exp_upd;

        rst           = 1'b0;
        set_alloc(1'b0, '0, 1'b0, 1'b0, 1'b0);
        resolve_valid = 1'b0;
        resolve_taken = 1'b0;

        // ---------------- reset state ----------------
        #22;
        check_idle_outputs("rst");
        rst = 1'b1;
        step();
        check("rst_aready", 32'(alloc_ready), 32'd1);
        check("rst_rready", 32'(resolve_ready), 32'd1);

        // ---------------- basic alloc / resolve ----------------
        set_alloc(1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
        #1;
        check("t1_pred", 32'(pred_taken), 32'd1);
        step();
        set_alloc(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check("t1_count", 32'(count), 32'd1);
        resolve_valid = 1'b1;
        resolve_taken = 1'b1;
        step();
        resolve_valid = 1'b0;
        check("t1_p1cor", 32'(p1_cor), 32'd1);
        check("t1_p2cor", 32'(p2_cor), 32'd0);
        check("t1_uidx", 32'(upd_idx), 32'd3);
        check("t1_utaken", 32'(upd_taken), 32'd1);
        check("t1_mis", 32'(mispredict), 32'd0);
        check("t1_upd_setup", 32'(update), 32'd0);
        check("t1_rready_setup", 32'(resolve_ready), 32'd0);
        check("t1_count0", 32'(count), 32'd0);
        step();
        check("t1_upd_pulse", 32'(update), 32'd1);
        check("t1_rready_pulse", 32'(resolve_ready), 32'd0);
        step();
        check("t1_upd_idle", 32'(update), 32'd0);
        check("t1_rready_idle", 32'(resolve_ready), 32'd1);

        // ---------------- mispredict squash ----------------
        for (int i = 0; i < 3; i++) begin
            set_alloc(1'b1, 5'(10 + i), 1'b1, 1'b0, 1'b1);
            #1;
            check("t2_pred", 32'(pred_taken), 32'd0);
            step();
        end
        set_alloc(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check("t2_count3", 32'(count), 32'd3);
        set_alloc(1'b1, 5'd20, 1'b0, 1'b0, 1'b0);
        resolve_valid = 1'b1;
        resolve_taken = 1'b1;
        step();
        set_alloc(1'b0, '0, 1'b0, 1'b0, 1'b0);
        resolve_valid = 1'b0;
        check("t2_mis", 32'(mispredict), 32'd1);
        check("t2_count0", 32'(count), 32'd0);
        check("t2_uidx", 32'(upd_idx), 32'd10);
        check("t2_p1cor", 32'(p1_cor), 32'd1);
        check("t2_p2cor", 32'(p2_cor), 32'd0);
        step();
        check("t2_mis_drop", 32'(mispredict), 32'd0);
        check("t2_count_still0", 32'(count), 32'd0);
        step();
        // allocation resumes; dropped entry 20 must not appear
        set_alloc(1'b1, 5'd21, 1'b1, 1'b1, 1'b0);
        step();
        set_alloc(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check("t2_resume_count", 32'(count), 32'd1);
        resolve_valid = 1'b1;
        resolve_taken = 1'b1;
        step();
        resolve_valid = 1'b0;
        check("t2_resume_uidx", 32'(upd_idx), 32'd21);
        check("t2_resume_mis", 32'(mispredict), 32'd0);
        step();
        step();

        // ---------------- fill, full refusal, pointer wrap ----------------
        for (int i = 0; i < DEPTH; i++) begin
            set_alloc(1'b1, 5'(i), 1'b1, 1'b1, 1'b0);
            step();
        end
        check("t3_count8", 32'(count), 32'd8);
        check("t3_aready_full", 32'(alloc_ready), 32'd0);
        set_alloc(1'b1, 5'd30, 1'b1, 1'b1, 1'b0);
        resolve_valid = 1'b1;
        resolve_taken = 1'b1;
        step();
        set_alloc(1'b0, '0, 1'b0, 1'b0, 1'b0);
        resolve_valid = 1'b0;
        check("t3_count7", 32'(count), 32'd7);
        check("t3_uidx0", 32'(upd_idx), 32'd0);
        step();
        step();
        for (int k = 0; k < 12; k++) begin
            set_alloc(1'b1, 5'(8 + k), 1'b1, 1'b1, 1'b0);
            resolve_valid = 1'b1;
            resolve_taken = 1'b1;
            step();
            set_alloc(1'b0, '0, 1'b0, 1'b0, 1'b0);
            resolve_valid = 1'b0;
            check("t3_wrap_uidx", 32'(upd_idx), 32'(1 + k));
            check("t3_wrap_count", 32'(count), 32'd7);
            step();
            step();
        end
        for (int k = 0; k < 7; k++) begin
            resolve_valid = 1'b1;
            resolve_taken = 1'b1;
            step();
            resolve_valid = 1'b0;
            check("t3_drain_uidx", 32'(upd_idx), 32'(13 + k));
            step();
            step();
        end
        check("t3_drained", 32'(count), 32'd0);

        // ---------------- resolve on empty queue ----------------
        resolve_valid = 1'b1;
        resolve_taken = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t4_update", 32'(update), 32'd0);
            check("t4_rready", 32'(resolve_ready), 32'd1);
        end
        resolve_valid = 1'b0;
        check("t4_count", 32'(count), 32'd0);
        check("t4_uidx", 32'(upd_idx), 32'd19);
        check("t4_utaken", 32'(upd_taken), 32'd1);
        check("t4_p1cor", 32'(p1_cor), 32'd1);

        // ---------------- back-to-back resolve spacing ----------------
        for (int i = 0; i < 4; i++) begin
            set_alloc(1'b1, 5'(24 + i), 1'b0, 1'b1, 1'b1);
            step();
        end
        set_alloc(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check("t5_count4", 32'(count), 32'd4);
        resolve_valid = 1'b1;
        resolve_taken = 1'b1;
        pulses = 0;
        for (int i = 0; i < 14; i++) begin
            step();
            exp_upd = (i < 12) && (i % 3 == 1);
            check("t5_update", 32'(update), 32'(exp_upd));
            if (update) pulses++;
            if (i < 12 && (i % 3 != 2)) begin
                check("t5_p1cor", 32'(p1_cor), 32'd0);
                check("t5_p2cor", 32'(p2_cor), 32'd1);
                check("t5_uidx", 32'(upd_idx), 32'(24 + i / 3));
            end
        end
        resolve_valid = 1'b0;
        check("t5_pulses", 32'(pulses), 32'd4);
        check("t5_count0", 32'(count), 32'd0);

        // ---------------- reset during PULSE ----------------
        set_alloc(1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
        step();
        set_alloc(1'b1, 5'd6, 1'b1, 1'b1, 1'b0);
        step();
        set_alloc(1'b0, '0, 1'b0, 1'b0, 1'b0);
        resolve_valid = 1'b1;
        resolve_taken = 1'b1;
        step();
        resolve_valid = 1'b0;
        step();
        check("t6_in_pulse", 32'(update), 32'd1);
        #1;
        rst = 1'b0;
        #1;
        check("t6_update_async", 32'(update), 32'd0);
        check_idle_outputs("t6_rst");
        #3;
        rst = 1'b1;
        step();
        check("t6_update_after", 32'(update), 32'd0);
        check("t6_rready", 32'(resolve_ready), 32'd1);
        check("t6_aready", 32'(alloc_ready), 32'd1);
        check_idle_outputs("t6_post");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
